fetch_stage: RTL and testbench

- Instruction fetch unit and IF/ID pipeline register for the AlphaOne core.
- Owns the PC and issues one instruction-memory request at a time.
- Captures the returned word and presents the instruction, its opcode field and its PC to decode.
- The opcode and instruction outputs feed the immediate generator and the control decoder directly.
- Handles decode-stage stall and EX-stage redirect (taken branch, JAL, JALR).

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, single-outstanding instruction fetch and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectEn,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic [31:0] instOut,
    output logic [6:0]  opcode,
    output logic [31:0] pcOut,
    output logic        instValid,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, pc_out_q, pc_out_d, skid_q, skid_d;
    logic        req_q, req_d, valid_q, valid_d, drop_q, drop_d, mis_q, mis_d;
    logic        free, take, load_mem, load_skid;

    // IF/ID can take a word when decode consumes it or it holds a bubble
    assign free      = !stall || !valid_q;
    assign take      = state_q == WAIT && imemValid && !drop_q;
    assign load_mem  = take && free;
    assign load_skid = state_q == HOLD && !stall;

    assign imemReq   = req_q;
    assign imemAddr  = addr_q;
    assign instOut   = inst_q;
    assign opcode    = inst_q[6:0];
    assign pcOut     = pc_out_q;
    assign instValid = valid_q;
    assign misalign  = mis_q;

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            req_q    <= 1'b0;
            inst_q   <= NOP_INST;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            skid_q   <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            skid_q   <= skid_d;
            mis_q    <= mis_d;
        end
    end

    // next state: a redirect restarts fetch unless a request is still in flight
    always_comb begin
        state_d = state_q;
        if (redirectEn)
            state_d = (state_q == WAIT && !imemValid) ? WAIT : REQ;
        else
            case (state_q)
                IDLE: state_d = REQ;
                REQ:  state_d = WAIT;
                WAIT: if (imemValid) state_d = (take && !free) ? HOLD : REQ;
                HOLD: if (!stall) state_d = REQ;
            endcase
    end

    // datapath next values: request strobe, IF/ID load/bubble/hold, skid, drop
    always_comb begin
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = 1'b0;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        skid_d   = skid_q;
        mis_d    = redirectEn && |redirectPc[1:0];
        if (redirectEn) begin
            pc_d    = {redirectPc[31:2], 2'b00};
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            skid_d  = '0;
            drop_d  = state_q == WAIT && !imemValid;
        end else begin
            if (state_q == REQ) begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end
            if (state_q == WAIT && imemValid && drop_q)
                drop_d = 1'b0;
            if (take && !free)
                skid_d = imemRdata;
            if (load_mem || load_skid) begin
                inst_d   = load_mem ? imemRdata : skid_q;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_q + 32'd4;
            end else if (!stall) begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle-exact checks of fetch_stage against a simple memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirectEn = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata = '0;
    logic        imemValid = 1'b0;
    logic [31:0] instOut;
    logic [6:0]  opcode;
    logic [31:0] pcOut;
    logic        instValid;
    logic        misalign;

    logic [31:0] mem [16];
    logic [31:0] rsp_addr = '0;
    int          rsp_cnt = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_err = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirectEn(redirectEn), .redirectPc(redirectPc),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemRdata(imemRdata), .imemValid(imemValid),
        .instOut(instOut), .opcode(opcode), .pcOut(pcOut), .instValid(instValid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to 1ns after the next rising edge and play the memory's response
    task automatic tick();
        @(posedge clk);
        #1;
        imemValid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imemValid = 1'b1;
                imemRdata = mem[rsp_addr[5:2]];
            end
        end
        if (imemReq) begin
            rsp_cnt  = lat;
            rsp_addr = imemAddr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rsp_cnt   = 0;
        imemValid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] w, input logic [31:0] pc);
        logic [31:0] op;
        op = {25'b0, w[6:0]};
        chk({tag, ".inst"}, instOut, w);
        chk({tag, ".op"}, {25'b0, opcode}, op);
        chk({tag, ".pc"}, pcOut, pc);
        chk({tag, ".valid"}, {31'b0, instValid}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req"}, {31'b0, imemReq}, 32'd0);
        chk({tag, ".addr"}, imemAddr, 32'd0);
        chk({tag, ".inst"}, instOut, 32'h0000_0013);
        chk({tag, ".op"}, {25'b0, opcode}, 32'h13);
        chk({tag, ".pc"}, pcOut, 32'd0);
        chk({tag, ".valid"}, {31'b0, instValid}, 32'd0);
        chk({tag, ".mis"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0093 | (32'(i) << 20);
        mem[0] = 32'h0050_0093;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // reset release and first fetches
        tick();
        chk("c1.req", {31'b0, imemReq}, 32'd0);
        tick();
        chk("c2.req", {31'b0, imemReq}, 32'd1);
        chk("c2.addr", imemAddr, 32'd0);
        tick();
        tick();
        chk_ifid("c4", 32'h0050_0093, 32'd0);
        tick();
        chk("c5.req", {31'b0, imemReq}, 32'd1);
        chk("c5.addr", imemAddr, 32'd4);
        chk("c5.bubble", {31'b0, instValid}, 32'd0);

        // sequential LUI / JAL / BEQ
        mem[0] = 32'h1234_5237;
        mem[1] = 32'h0080_00EF;
        mem[2] = 32'h0020_8463;
        mem[3] = 32'h00C5_8633;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i > 0) chk("seq.bubble", {31'b0, instValid}, 32'd0);
            tick();
            tick();
            chk_ifid("seq", mem[i], 32'(i * 4));
        end

        // stall across a response: word parks in skid until release
        stall = 1'b1;
        tick();
        chk("st.req", {31'b0, imemReq}, 32'd1);
        chk("st.addr", imemAddr, 32'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st.noreq", {31'b0, imemReq}, 32'd0);
            chk_ifid("st.hold", mem[2], 32'd8);
        end
        stall = 1'b0;
        tick();
        chk_ifid("st.rel", mem[3], 32'd12);
        lat = 2;
        tick();
        chk("st.next", imemAddr, 32'd16);
        chk("st.nreq", {31'b0, imemReq}, 32'd1);

        // redirect while waiting; stale response two cycles later is dropped
        redirectEn = 1'b1;
        redirectPc = 32'h100;
        tick();
        redirectEn = 1'b0;
        chk("rd.valid", {31'b0, instValid}, 32'd0);
        chk("rd.inst", instOut, 32'h0000_0013);
        chk("rd.mis", {31'b0, misalign}, 32'd0);
        tick();
        tick();
        chk("rd.drop", {31'b0, instValid}, 32'd0);
        chk("rd.noreq", {31'b0, imemReq}, 32'd0);
        lat = 1;
        tick();
        chk("rd.req", {31'b0, imemReq}, 32'd1);
        chk("rd.addr", imemAddr, 32'h100);
        tick();
        tick();
        chk_ifid("rd.ld", mem[0], 32'h100);

        // redirect colliding with a response, misaligned target
        tick();
        chk("mc.addr", imemAddr, 32'h104);
        tick();
        redirectEn = 1'b1;
        redirectPc = 32'h202;
        tick();
        redirectEn = 1'b0;
        chk("mc.mis", {31'b0, misalign}, 32'd1);
        chk("mc.valid", {31'b0, instValid}, 32'd0);
        chk("mc.noreq", {31'b0, imemReq}, 32'd0);
        tick();
        chk("mc.mis0", {31'b0, misalign}, 32'd0);
        chk("mc.req", {31'b0, imemReq}, 32'd1);
        chk("mc.addr2", imemAddr, 32'h200);
        tick();
        chk("mc.single", {31'b0, imemReq}, 32'd0);
        tick();
        chk_ifid("mc.ld", mem[0], 32'h200);

        // redirect to the top word, then wrap to zero
        redirectEn = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        redirectEn = 1'b0;
        chk("wr.noreq", {31'b0, imemReq}, 32'd0);
        chk("wr.inst", instOut, 32'h0000_0013);
        chk("wr.mis", {31'b0, misalign}, 32'd0);
        tick();
        chk("wr.addr", imemAddr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk_ifid("wr.ld", mem[15], 32'hFFFF_FFFC);
        tick();
        chk("wr.req", {31'b0, imemReq}, 32'd1);
        chk("wr.zero", imemAddr, 32'd0);

        // asynchronous reset while a request is in flight
        rst = 1'b1;
        #2;
        chk_reset_vals("arst");
        tick();
        rst = 1'b0;
        tick();
        chk("ar.valid", {31'b0, instValid}, 32'd0);
        chk("ar.noreq", {31'b0, imemReq}, 32'd0);
        tick();
        chk("ar.req", {31'b0, imemReq}, 32'd1);
        chk("ar.addr", imemAddr, 32'd0);
        tick();
        tick();
        chk_ifid("ar.ld", mem[0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
